uart_rx_deserializer: RTL and testbench

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

---
 rtl/uart_rx_deserializer.sv | 158 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronizer, falling-edge start detection,
// mid-bit sampling, optional even parity, and registered one-cycle
// result pulses (rx_valid / parity_err / frame_err).
module uart_rx_deserializer #(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 16,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUD_DIV/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                sync1_q, rx_s_q, rx_d_q;
  logic                mismatch;

  // Synchronizer and edge-detect delay; reset to idle-high so reset
  // release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  // Even parity: data bits plus parity bit must XOR to zero.
  assign mismatch = (^shift_q) ^ par_q;

  // Next-state, counters, shift register and result pulses.
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!rx_s_q && rx_d_q) state_d = START;
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = IDLE;
          if (!rx_s_q)                          ferr_d = 1'b1;
          else if ((PARITY_EN != 0) && mismatch) perr_d = 1'b1;
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any frame activity; the last good word is kept.
    if (clear) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = '0;
      par_d   = 1'b0;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (DATA_W=8, BAUD_DIV=16, parity on).
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst, clear, rx_i;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, busy;

  uart_rx_deserializer #(.DATA_W(8), .BAUD_DIV(16), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .rx_i(rx_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the falling edge
  int   n_valid = 0, n_perr = 0, n_ferr = 0, n_multi = 0;
  int   last_valid_edge = 0;
  logic busy_at_valid = 1'b1;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_edge = cyc - 1;
      busy_at_valid   = busy;
    end
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if ((32'(rx_valid) + 32'(parity_err) + 32'(frame_err)) > 1) n_multi++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_i = 1'b1;
    end
  endtask

  // Drive the first ncyc bit-clock cycles of a frame; edge0 is the first
  // rising edge that samples the start bit low.
  int edge0 = 0;
  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s, input int ncyc);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) edge0 = cyc;
      rx_i = bits[c / 16];
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         ev, ep, ef;
    logic [7:0] edata;
    logic       tm;   // also check pulse timing
  } vec_t;

  vec_t tbl[7];
  int   bv, bp, bf;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5, 1'b1};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 0, 1, 0, 8'hA5, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 1, 0, 0, 8'h80, 1'b0};
    tbl[4] = '{8'h7E, 1'b0, 1'b0, 0, 0, 1, 8'h80, 1'b0};
    tbl[5] = '{8'hC3, 1'b1, 1'b0, 0, 0, 1, 8'h80, 1'b0};
    tbl[6] = '{8'hFE, 1'b1, 1'b1, 1, 0, 0, 8'hFE, 1'b0};

    rst = 1'b1; clear = 1'b0; rx_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rx_data), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_perr",  32'(parity_err), 0);
    chk("rst_ferr",  32'(frame_err), 0);
    chk("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    idle(5);
    chk("post_rst_busy", 32'(busy), 0);

    // table of complete frames
    for (int i = 0; i < 7; i++) begin
      bv = n_valid; bp = n_perr; bf = n_ferr;
      drive_frame(tbl[i].d, tbl[i].p, tbl[i].s, 176);
      idle(20);
      chk($sformatf("v%0d_valid", i), 32'(n_valid - bv), 32'(tbl[i].ev));
      chk($sformatf("v%0d_perr", i),  32'(n_perr - bp),  32'(tbl[i].ep));
      chk($sformatf("v%0d_ferr", i),  32'(n_ferr - bf),  32'(tbl[i].ef));
      chk($sformatf("v%0d_data", i),  32'(rx_data), 32'(tbl[i].edata));
      chk($sformatf("v%0d_busy", i),  32'(busy), 0);
      if (tbl[i].tm) begin
        chk("valid_edge",    32'(last_valid_edge - edge0), 170);
        chk("busy_at_valid", 32'(busy_at_valid), 0);
      end
    end

    // break: bad stop then line held low
    bv = n_valid; bp = n_perr; bf = n_ferr;
    drive_frame(8'h3C, 1'b0, 1'b0, 176);
    repeat (500) begin
      @(negedge clk);
      rx_i = 1'b0;
    end
    chk("brk_ferr",  32'(n_ferr - bf), 1);
    chk("brk_valid", 32'(n_valid - bv), 0);
    chk("brk_perr",  32'(n_perr - bp), 0);
    chk("brk_busy",  32'(busy), 0);
    chk("brk_data",  32'(rx_data), 32'h0FE);
    idle(20);
    chk("brk_release_pulses", 32'((n_valid - bv) + (n_perr - bp) + (n_ferr - bf)), 1);

    // glitch: 4 low cycles, start rejected at edge 10
    bv = n_valid; bp = n_perr; bf = n_ferr;
    @(negedge clk);
    edge0 = cyc;
    rx_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rx_i = 1'b0;
    end
    @(negedge clk);
    rx_i = 1'b1;
    while ((cyc - 1 - edge0) < 9) @(negedge clk);
    chk("glitch_busy_e9", 32'(busy), 1);
    @(negedge clk);
    chk("glitch_busy_e10", 32'(busy), 0);
    idle(20);
    chk("glitch_pulses", 32'((n_valid - bv) + (n_perr - bp) + (n_ferr - bf)), 0);

    // clear at edge 80, then a clean 0x5A
    bv = n_valid; bp = n_perr; bf = n_ferr;
    drive_frame(8'h33, 1'b0, 1'b1, 80);
    chk("clr_busy_before", 32'(busy), 1);
    @(negedge clk);
    clear = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy_after", 32'(busy), 0);
    chk("clr_data_kept",  32'(rx_data), 32'h0FE);
    idle(30);
    chk("clr_no_pulse", 32'((n_valid - bv) + (n_perr - bp) + (n_ferr - bf)), 0);
    drive_frame(8'h5A, 1'b0, 1'b1, 176);
    idle(20);
    chk("clr_valid", 32'(n_valid - bv), 1);
    chk("clr_err",   32'((n_perr - bp) + (n_ferr - bf)), 0);
    chk("clr_data",  32'(rx_data), 32'h05A);

    // rst at edge 100, then 0xFF
    bv = n_valid; bp = n_perr; bf = n_ferr;
    drive_frame(8'h96, 1'b0, 1'b1, 100);
    @(negedge clk);
    rst  = 1'b1;
    rx_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_data",  32'(rx_data), 0);
    chk("mrst_valid", 32'(rx_valid), 0);
    chk("mrst_perr",  32'(parity_err), 0);
    chk("mrst_ferr",  32'(frame_err), 0);
    chk("mrst_busy",  32'(busy), 0);
    idle(20);
    chk("mrst_no_pulse", 32'((n_valid - bv) + (n_perr - bp) + (n_ferr - bf)), 0);
    drive_frame(8'hFF, 1'b0, 1'b1, 176);
    idle(20);
    chk("ff_valid", 32'(n_valid - bv), 1);
    chk("ff_err",   32'((n_perr - bp) + (n_ferr - bf)), 0);
    chk("ff_data",  32'(rx_data), 32'h0FF);

    chk("pulses_exclusive", 32'(n_multi), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
